// File: rtl/rv32ima_pkg.sv
// Shared RV32IMA types: SYSTEM funct3 encodings, machine-mode CSR addresses and fixed CSR constants.
package rv32ima_pkg;

   typedef enum logic [2:0] {
      SYS_PRIV   = 3'b000,
      SYS_CSRRW  = 3'b001,
      SYS_CSRRS  = 3'b010,
      SYS_CSRRC  = 3'b011,
      SYS_CSRRWI = 3'b101,
      SYS_CSRRSI = 3'b110,
      SYS_CSRRCI = 3'b111
   } system_funct3_t;

   typedef enum logic [11:0] {
      CSR_MSTATUS   = 12'h300,
      CSR_MISA      = 12'h301,
      CSR_MTVEC     = 12'h305,
      CSR_MSCRATCH  = 12'h340,
      CSR_MEPC      = 12'h341,
      CSR_MCAUSE    = 12'h342,
      CSR_MCYCLE    = 12'hB00,
      CSR_MINSTRET  = 12'hB02,
      CSR_MCYCLEH   = 12'hB80,
      CSR_MINSTRETH = 12'hB82,
      CSR_CYCLE     = 12'hC00,
      CSR_INSTRET   = 12'hC02,
      CSR_CYCLEH    = 12'hC80,
      CSR_INSTRETH  = 12'hC82,
      CSR_MHARTID   = 12'hF14
   } csr_addr_t;

   localparam int          MSTATUS_MIE_BIT  = 3;
   localparam int          MSTATUS_MPIE_BIT = 7;
   localparam logic [31:0] MISA_VALUE       = 32'h4000_1101;

endpackage

// File: rtl/csr_counter.sv
// Wide free-running counter with independently writable low/high XLEN halves.
// A write to either half replaces only that half and suppresses the increment for that cycle.
module csr_counter #(
   parameter int CNT_WIDTH = 64,
   parameter int XLEN      = 32
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 inc,
   input  logic                 wr_lo,
   input  logic                 wr_hi,
   input  logic [XLEN-1:0]      wdata,
   output logic [CNT_WIDTH-1:0] count
);

   localparam int HI_W = CNT_WIDTH - XLEN;

   logic [CNT_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (wr_lo) count_d[XLEN-1:0] = wdata;
      if (wr_hi) count_d[CNT_WIDTH-1:XLEN] = wdata[HI_W-1:0];
      if (!(wr_lo || wr_hi) && inc) count_d = count_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr read-modify-write, mcycle/minstret, trap entry and MRET.
// Reads are combinational (old value); all state updates commit on the next rising clk edge.
module csr_file
   import rv32ima_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              CNT_WIDTH   = 64,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0,
   parameter int              HART_ID     = 0
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [11:0]     csr_index,
   input  logic [2:0]      csr_opcode,
   input  logic            csr_ren,
   input  logic            csr_wen,
   input  logic [XLEN-1:0] reg_val,
   input  logic [4:0]      uimm,
   output logic [XLEN-1:0] csr_val,
   output logic            illegal,
   input  logic            instr_retire,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret,
   output logic [XLEN-1:0] trap_vector,
   output logic [XLEN-1:0] mepc_out
);

   logic            mie_q, mie_d, mpie_q, mpie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;

   logic [CNT_WIDTH-1:0] mcycle, minstret;
   logic [XLEN-1:0]      mcycle_hi, minstret_hi, mstatus_rd;
   logic [XLEN-1:0]      old_val, src, new_val;
   logic                 implemented, wr_en;

   always_comb begin
      mstatus_rd                   = '0;
      mstatus_rd[12:11]            = 2'b11;
      mstatus_rd[MSTATUS_MIE_BIT]  = mie_q;
      mstatus_rd[MSTATUS_MPIE_BIT] = mpie_q;
      // High halves are zero-extended when CNT_WIDTH < 2*XLEN.
      mcycle_hi                          = '0;
      mcycle_hi[CNT_WIDTH-XLEN-1:0]      = mcycle[CNT_WIDTH-1:XLEN];
      minstret_hi                        = '0;
      minstret_hi[CNT_WIDTH-XLEN-1:0]    = minstret[CNT_WIDTH-1:XLEN];
   end

   always_comb begin
      old_val     = '0;
      implemented = 1'b1;
      case (csr_index)
         CSR_MSTATUS:                old_val = mstatus_rd;
         CSR_MISA:                   old_val = XLEN'(MISA_VALUE);
         CSR_MTVEC:                  old_val = mtvec_q;
         CSR_MSCRATCH:               old_val = mscratch_q;
         CSR_MEPC:                   old_val = mepc_q;
         CSR_MCAUSE:                 old_val = mcause_q;
         CSR_MCYCLE,   CSR_CYCLE:    old_val = mcycle[XLEN-1:0];
         CSR_MCYCLEH,  CSR_CYCLEH:   old_val = mcycle_hi;
         CSR_MINSTRET, CSR_INSTRET:  old_val = minstret[XLEN-1:0];
         CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret_hi;
         CSR_MHARTID:                old_val = XLEN'(HART_ID);
         default:                    implemented = 1'b0;
      endcase
   end

   always_comb begin
      src = csr_opcode[2] ? {{(XLEN-5){1'b0}}, uimm} : reg_val;
      case (system_funct3_t'(csr_opcode))
         SYS_CSRRW, SYS_CSRRWI: new_val = src;
         SYS_CSRRS, SYS_CSRRSI: new_val = old_val | src;
         SYS_CSRRC, SYS_CSRRCI: new_val = old_val & ~src;
         default:               new_val = old_val;
      endcase
   end

   assign illegal = ((csr_ren || csr_wen) && !implemented) ||
                    (csr_wen && (csr_index[11:10] == 2'b11));
   assign csr_val = (csr_ren || csr_wen) ? old_val : '0;
   assign wr_en   = csr_wen && !illegal && !trap_req;

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      if (trap_req) begin
         mepc_d   = trap_pc & ~XLEN'(3);
         mcause_d = trap_cause;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else begin
         if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
         end
         if (wr_en) begin
            case (csr_index)
               CSR_MSTATUS: begin
                  // An MRET in the same cycle owns mstatus; the write is dropped.
                  if (!mret) begin
                     mie_d  = new_val[MSTATUS_MIE_BIT];
                     mpie_d = new_val[MSTATUS_MPIE_BIT];
                  end
               end
               CSR_MTVEC:    mtvec_d    = new_val & ~XLEN'(3);
               CSR_MSCRATCH: mscratch_d = new_val;
               CSR_MEPC:     mepc_d     = new_val & ~XLEN'(3);
               CSR_MCAUSE:   mcause_d   = new_val;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET & ~XLEN'(3);
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
      end
   end

   csr_counter #(.CNT_WIDTH(CNT_WIDTH), .XLEN(XLEN)) u_mcycle (
      .clk   (clk),
      .nrst  (nrst),
      .inc   (1'b1),
      .wr_lo (wr_en && (csr_index == CSR_MCYCLE)),
      .wr_hi (wr_en && (csr_index == CSR_MCYCLEH)),
      .wdata (new_val),
      .count (mcycle)
   );

   csr_counter #(.CNT_WIDTH(CNT_WIDTH), .XLEN(XLEN)) u_minstret (
      .clk   (clk),
      .nrst  (nrst),
      .inc   (instr_retire),
      .wr_lo (wr_en && (csr_index == CSR_MINSTRET)),
      .wr_hi (wr_en && (csr_index == CSR_MINSTRETH)),
      .wdata (new_val),
      .count (minstret)
   );

   assign trap_vector = {mtvec_q[XLEN-1:2], 2'b00};
   assign mepc_out    = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic against a behavioural model.
module tb_csr_file;

   logic        clk = 1'b0;
   logic        nrst;
   logic [11:0] csr_index;
   logic [2:0]  csr_opcode;
   logic        csr_ren, csr_wen;
   logic [31:0] reg_val;
   logic [4:0]  uimm;
   logic [31:0] csr_val;
   logic        illegal;
   logic        instr_retire, trap_req, mret;
   logic [31:0] trap_cause, trap_pc;
   logic [31:0] trap_vector, mepc_out;

   int checks = 0;
   int failures = 0;

   // Architectural state as the model sees it.
   logic        m_mie, m_mpie;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
   logic [63:0] m_cyc, m_ins;

   always #5 clk = ~clk;

   csr_file dut (
      .clk          (clk),
      .nrst         (nrst),
      .csr_index    (csr_index),
      .csr_opcode   (csr_opcode),
      .csr_ren      (csr_ren),
      .csr_wen      (csr_wen),
      .reg_val      (reg_val),
      .uimm         (uimm),
      .csr_val      (csr_val),
      .illegal      (illegal),
      .instr_retire (instr_retire),
      .trap_req     (trap_req),
      .trap_cause   (trap_cause),
      .trap_pc      (trap_pc),
      .mret         (mret),
      .trap_vector  (trap_vector),
      .mepc_out     (mepc_out)
   );

   function automatic logic m_impl(input logic [11:0] a);
      case (a)
         12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
         12'hB00, 12'hB80, 12'hB02, 12'hB82,
         12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 + (m_mie ? 32'd8 : 32'd0) + (m_mpie ? 32'd128 : 32'd0);
         12'h301: return 32'h4000_1101;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'hB00, 12'hC00: return m_cyc[31:0];
         12'hB80, 12'hC80: return m_cyc[63:32];
         12'hB02, 12'hC02: return m_ins[31:0];
         12'hB82, 12'hC82: return m_ins[63:32];
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic m_illegal();
      return ((csr_ren || csr_wen) && !m_impl(csr_index)) ||
             (csr_wen && csr_index[11:10] == 2'b11);
   endfunction

   function automatic logic [31:0] m_val();
      return (csr_ren || csr_wen) ? m_read(csr_index) : 32'h0;
   endfunction

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_cyc = 0; m_ins = 0;
   endtask

   task automatic model_update();
      logic [31:0] old_v, src, nv;
      logic [63:0] cyc_n, ins_n;
      old_v = m_read(csr_index);
      src   = csr_opcode[2] ? {27'h0, uimm} : reg_val;
      case (csr_opcode[1:0])
         2'b01:   nv = src;
         2'b10:   nv = old_v | src;
         2'b11:   nv = old_v & ~src;
         default: nv = old_v;
      endcase
      cyc_n = m_cyc + 64'd1;
      ins_n = m_ins + (instr_retire ? 64'd1 : 64'd0);
      if (trap_req) begin
         m_mepc = {trap_pc[31:2], 2'b00}; m_mcause = trap_cause;
         m_mpie = m_mie; m_mie = 0;
      end else begin
         if (csr_wen && !m_illegal()) begin
            case (csr_index)
               12'h300: if (!mret) begin m_mie = nv[3]; m_mpie = nv[7]; end
               12'h305: m_mtvec = {nv[31:2], 2'b00};
               12'h340: m_mscratch = nv;
               12'h341: m_mepc = {nv[31:2], 2'b00};
               12'h342: m_mcause = nv;
               12'hB00: cyc_n = {m_cyc[63:32], nv};
               12'hB80: cyc_n = {nv, m_cyc[31:0]};
               12'hB02: ins_n = {m_ins[63:32], nv};
               12'hB82: ins_n = {nv, m_ins[31:0]};
               default: ;
            endcase
         end
         if (mret) begin m_mie = m_mpie; m_mpie = 1; end
      end
      m_cyc = cyc_n;
      m_ins = ins_n;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      csr_index = 12'h0; csr_opcode = 3'b000; csr_ren = 0; csr_wen = 0;
      reg_val = 0; uimm = 0; instr_retire = 0; trap_req = 0; mret = 0;
      trap_cause = 0; trap_pc = 0;
   endtask

   task automatic cmd(input logic [11:0] idx, input logic [2:0] op, input logic r, input logic w,
                      input logic [31:0] rv, input logic [4:0] ui);
      csr_index = idx; csr_opcode = op; csr_ren = r; csr_wen = w; reg_val = rv; uimm = ui;
   endtask

   task automatic rd(input logic [11:0] idx);
      idle();
      cmd(idx, 3'b010, 1, 0, 32'h0, 5'h0);
      #1;
   endtask

   task automatic test_reset();
      idle();
      #1;
      checks++; if (csr_val !== 32'h0) begin failures++; $display("FAIL reset_csr_val got %h exp %h", csr_val, 32'h0); end
      checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got %b exp 0", illegal); end
      checks++; if (trap_vector !== 32'h0) begin failures++; $display("FAIL reset_trap_vector got %h exp 0", trap_vector); end
      checks++; if (mepc_out !== 32'h0) begin failures++; $display("FAIL reset_mepc got %h exp 0", mepc_out); end
      rd(12'h300);
      checks++; if (csr_val !== 32'h1800) begin failures++; $display("FAIL reset_mstatus got %h exp %h", csr_val, 32'h1800); end
      rd(12'hB00);
      checks++; if (csr_val !== 32'h0) begin failures++; $display("FAIL reset_mcycle got %h exp 0", csr_val); end
   endtask

   task automatic test_rw_basic();
      idle(); cmd(12'h340, 3'b001, 1, 1, 32'hDEADBEEF, 0); #1;
      checks++; if (csr_val !== 32'h0) begin failures++; $display("FAIL rw_old got %h exp 0", csr_val); end
      tick();
      rd(12'h340);
      checks++; if (csr_val !== 32'hDEADBEEF) begin failures++; $display("FAIL rw_new got %h exp DEADBEEF", csr_val); end
      tick();
   endtask

   task automatic test_warl();
      idle(); cmd(12'h340, 3'b001, 1, 1, 32'hF0F0F0F0, 0); tick();
      idle(); cmd(12'h340, 3'b111, 1, 1, 32'h0, 5'h1F); #1;
      checks++; if (csr_val !== 32'hF0F0F0F0) begin failures++; $display("FAIL rci_old got %h exp F0F0F0F0", csr_val); end
      tick();
      rd(12'h340);
      checks++; if (csr_val !== 32'hF0F0F0E0) begin failures++; $display("FAIL rci_new got %h exp F0F0F0E0", csr_val); end
      idle(); cmd(12'h305, 3'b001, 1, 1, 32'h100, 0); tick();
      idle(); cmd(12'h305, 3'b110, 1, 1, 32'h0, 5'h3); tick();
      rd(12'h305);
      checks++; if (csr_val !== 32'h100) begin failures++; $display("FAIL mtvec_warl got %h exp 100", csr_val); end
      checks++; if (trap_vector !== 32'h100) begin failures++; $display("FAIL trap_vector got %h exp 100", trap_vector); end
      idle(); cmd(12'h341, 3'b001, 1, 1, 32'h1237, 0); tick();
      rd(12'h341);
      checks++; if (csr_val !== 32'h1234) begin failures++; $display("FAIL mepc_warl got %h exp 1234", csr_val); end
      idle(); cmd(12'h301, 3'b001, 1, 1, 32'h0, 0); #1;
      checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL misa_wr_illegal got %b exp 0", illegal); end
      tick();
      rd(12'h301);
      checks++; if (csr_val !== 32'h4000_1101) begin failures++; $display("FAIL misa got %h exp 40001101", csr_val); end
   endtask

   task automatic test_illegal();
      idle(); cmd(12'hC00, 3'b001, 1, 1, 32'h55, 0); #1;
      checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ro_cycle_illegal got %b exp 1", illegal); end
      tick();
      idle(); cmd(12'hF14, 3'b001, 1, 1, 32'h55, 0); #1;
      checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ro_hartid_illegal got %b exp 1", illegal); end
      tick();
      rd(12'hF14);
      checks++; if (csr_val !== 32'h0 || illegal !== 1'b0) begin failures++; $display("FAIL hartid_read got %h/%b exp 0/0", csr_val, illegal); end
      rd(12'h7C0);
      checks++; if (illegal !== 1'b1 || csr_val !== 32'h0) begin failures++; $display("FAIL unimpl_read got %h/%b exp 0/1", csr_val, illegal); end
      tick();
   endtask

   task automatic test_trap_mret();
      idle(); cmd(12'h300, 3'b110, 1, 1, 32'h0, 5'h8); tick();
      idle(); cmd(12'h340, 3'b001, 1, 1, 32'h55, 0); tick();
      idle(); cmd(12'h340, 3'b001, 1, 1, 32'hAAAA, 0);
      trap_req = 1; trap_pc = 32'h1006; trap_cause = 32'hB; tick();
      idle(); #1;
      checks++; if (mepc_out !== 32'h1004) begin failures++; $display("FAIL trap_mepc got %h exp 1004", mepc_out); end
      rd(12'h342);
      checks++; if (csr_val !== 32'hB) begin failures++; $display("FAIL trap_mcause got %h exp B", csr_val); end
      rd(12'h300);
      checks++; if (csr_val !== 32'h1880) begin failures++; $display("FAIL trap_mstatus got %h exp 1880", csr_val); end
      rd(12'h340);
      checks++; if (csr_val !== 32'h55) begin failures++; $display("FAIL trap_drop_write got %h exp 55", csr_val); end
      idle(); cmd(12'h300, 3'b001, 1, 1, 32'h0, 0); mret = 1; tick();
      rd(12'h300);
      checks++; if (csr_val !== 32'h1888) begin failures++; $display("FAIL mret_mstatus got %h exp 1888", csr_val); end
      idle(); cmd(12'h340, 3'b001, 1, 1, 32'h77, 0); mret = 1; tick();
      rd(12'h340);
      checks++; if (csr_val !== 32'h77) begin failures++; $display("FAIL mret_other_write got %h exp 77", csr_val); end
   endtask

   task automatic test_counters();
      idle(); cmd(12'hB00, 3'b001, 1, 1, 32'hFFFFFFFF, 0); tick();
      idle(); cmd(12'hB80, 3'b001, 1, 1, 32'h0, 0); tick();
      idle(); tick();
      rd(12'hB00);
      checks++; if (csr_val !== 32'h0) begin failures++; $display("FAIL carry_lo got %h exp 0", csr_val); end
      tick();
      rd(12'hC80);
      checks++; if (csr_val !== 32'h1) begin failures++; $display("FAIL carry_hi got %h exp 1", csr_val); end
      idle(); cmd(12'hB00, 3'b001, 1, 1, 32'hFFFFFFFF, 0); tick();
      idle(); cmd(12'hB80, 3'b001, 1, 1, 32'hFFFFFFFF, 0); tick();
      idle(); tick();
      rd(12'hB00);
      checks++; if (csr_val !== 32'h0) begin failures++; $display("FAIL wrap_lo got %h exp 0", csr_val); end
      tick();
      rd(12'hB80);
      checks++; if (csr_val !== 32'h0) begin failures++; $display("FAIL wrap_hi got %h exp 0", csr_val); end
      tick();
   endtask

   task automatic test_minstret();
      for (int i = 1; i <= 10; i++) begin
         idle();
         instr_retire = 1;
         if (i == 5) cmd(12'hB02, 3'b001, 1, 1, 32'h100, 0);
         tick();
      end
      rd(12'hB02);
      checks++; if (csr_val !== 32'h105) begin failures++; $display("FAIL minstret got %h exp 105", csr_val); end
      tick();
   endtask

   task automatic test_random();
      logic [11:0] addrs [17];
      logic [2:0]  ops [6];
      addrs = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80,
                12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h344};
      ops = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
      for (int n = 0; n < 400; n++) begin
         idle();
         cmd(addrs[$urandom_range(16, 0)], ops[$urandom_range(5, 0)], 1'($urandom),
             1'($urandom), $urandom, 5'($urandom));
         instr_retire = 1'($urandom);
         trap_req     = ($urandom_range(15, 0) == 0);
         mret         = ($urandom_range(9, 0) == 0);
         trap_pc      = $urandom;
         trap_cause   = $urandom;
         #1;
         checks++; if (csr_val !== m_val() || illegal !== m_illegal()) begin
            failures++;
            $display("FAIL rand_read[%0d] idx %h got %h/%b exp %h/%b", n, csr_index, csr_val, illegal, m_val(), m_illegal());
         end
         checks++; if (trap_vector !== m_mtvec || mepc_out !== m_mepc) begin
            failures++;
            $display("FAIL rand_vec[%0d] got %h/%h exp %h/%h", n, trap_vector, mepc_out, m_mtvec, m_mepc);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      idle(); cmd(12'h340, 3'b001, 1, 1, 32'h1234, 0);
      trap_req = 1; trap_pc = 32'h4000; trap_cause = 32'h7;
      #2 nrst = 0;
      #1;
      checks++; if (mepc_out !== 32'h0 || csr_val !== 32'h0) begin failures++; $display("FAIL async_reset got %h/%h exp 0/0", mepc_out, csr_val); end
      @(posedge clk);
      @(negedge clk);
      nrst = 1;
      model_reset();
      rd(12'h340);
      checks++; if (csr_val !== 32'h0) begin failures++; $display("FAIL reset_drop_write got %h exp 0", csr_val); end
      rd(12'h300);
      checks++; if (csr_val !== 32'h1800) begin failures++; $display("FAIL reset_mid_mstatus got %h exp 1800", csr_val); end
      rd(12'hB00);
      checks++; if (csr_val !== 32'h0) begin failures++; $display("FAIL reset_mid_mcycle got %h exp 0", csr_val); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      nrst = 0;
      idle();
      model_reset();
      repeat (2) @(negedge clk);
      nrst = 1;
      test_reset();
      test_rw_basic();
      test_warl();
      test_illegal();
      test_trap_mret();
      test_counters();
      test_minstret();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the RV32IMA core. It executes Zicsr read-modify-write commands (CSRRW/RS/RC and their immediate forms).
- Holds parametrised 64-bit cycle/instret counters.
- Performs trap entry and MRET state updates.
- Sits in the execute stage behind the CSR command/input bundle; supplies the trap vector and mepc to fetch.

Parameters:
XLEN, 32, data width of CSRs and operands
CNT_WIDTH, 64, width of mcycle/minstret counters (XLEN+1..2*XLEN legal)
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
HART_ID, 0, value returned by mhartid

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
csr_index  input  12  CSR address
csr_opcode  input  3  system_funct3_t: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
csr_ren  input  1  read requested
csr_wen  input  1  write requested (decoder clears it for RS/RC with zero source)
reg_val  input  XLEN  rs1 operand
uimm  input  5  immediate operand, zero-extended
csr_val  output  XLEN  old CSR value (combinational)
illegal  output  1  illegal CSR access (combinational)
instr_retire  input  1  one instruction retired this cycle
trap_req  input  1  take trap this cycle
trap_cause  input  XLEN  mcause value for trap
trap_pc  input  XLEN  faulting PC
mret  input  1  MRET executing
trap_vector  output  XLEN  {mtvec[XLEN-1:2],2'b00}
mepc_out  output  XLEN  current mepc

Behaviour:
- Reset (async, nrst=0) values:
  - mstatus.MIE=0, mstatus.MPIE=0
  - mtvec=MTVEC_RESET with bits[1:0]=0
  - mepc, mcause, mscratch = 0
  - counters = 0
  - outputs follow the combinational reset state: csr_val=0 unless read, illegal=0 when ren=wen=0.
- Implemented CSRs and read values:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11, other bits 0.
  - misa 0x301: reads 0x4000_1101; writes ignored, not illegal.
  - mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
  - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82.
  - Read-only: cycle 0xC00/0xC80, instret 0xC02/0xC82, mhartid 0xF14.
- Read: csr_val is the pre-write value of csr_index (combinational, zero latency). If ren=0 and wen=0, csr_val=0.
- High-half reads return counter bits [CNT_WIDTH-1:XLEN], zero-extended.
- Write operand: src = opcode[2] ? zext(uimm) : reg_val.
- Write result:
  - RW: new = src
  - RS: new = old | src
  - RC: new = old & ~src
- Writes commit at the next rising clk edge when wen=1 and illegal=0.
- WARL rules:
  - mtvec[1:0] and mepc[1:0] forced 0 (direct mode only).
  - mstatus writes only MIE/MPIE.
- illegal=1 when:
  - (ren|wen) and the index is unimplemented, or
  - wen and index[11:10]==2'b11 (read-only space).
- When illegal, no CSR state changes; counters still count.
- Counters:
  - mcycle increments every cycle; minstret increments when instr_retire=1.
  - Both wrap modulo 2^CNT_WIDTH.
  - A CSR write to either half replaces that half and suppresses that counter's increment for that cycle. The other half is unchanged.
- Trap entry (trap_req=1), at the edge:
  - mepc <= trap_pc & ~3, mcause <= trap_cause
  - MPIE <= MIE, MIE <= 0
  - Any concurrent CSR write is dropped. Counters are unaffected.
- MRET (mret=1, trap_req=0): MIE <= MPIE, MPIE <= 1.
- Priority: trap_req > mret > CSR write. Simultaneous mret and CSR write to mstatus: the mret update wins and the write is dropped. mret with writes to other CSRs: both take effect.
- Reset asserted mid-operation clears all state immediately, regardless of any pending write or trap.

Decomposition:
- rv32ima_pkg gains:
  - csr_addr_t enum of the addresses above
  - MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7
  - MISA_VALUE constant
  - system_funct3_t already exists there.
- One sub-module: csr_counter.
  - Parameters: CNT_WIDTH, XLEN.
  - Ports: clk, nrst, inc, wr_lo, wr_hi, wdata, count.
  - Instantiated twice (mcycle, minstret).

Test Plan:
- Reset, then CSRRW 0x340 with reg_val=0xDEADBEEF → csr_val=0 that cycle; next read returns 0xDEADBEEF.
- mscratch=0xF0F0F0F0, CSRRCI uimm=5'h1F → csr_val=0xF0F0F0F0; then reads 0xF0F0F0E0. CSRRSI uimm=0x3 on mtvec=0x100 → reads 0x100 (mode bits forced 0).
- CSRRW to 0xC00 → illegal=1, no change. Read of 0x7C0 → illegal=1, csr_val=0.
- mstatus MIE=1; trap_req with trap_pc=0x1006, cause=0xB, plus a simultaneous CSRRW mscratch → mepc=0x1004, mcause=0xB, mstatus=0x1880; mscratch unchanged. Then mret → mstatus=0x1888.
- Write mcycle=0xFFFFFFFF, mcycleh=0 → next cycles read mcycleh=1, mcycle=0. mcycle/mcycleh set to all-ones → wraps to 0.
- instr_retire held for 10 cycles with a minstret write in cycle 5 (value 0x100) → final minstret=0x105.
